// File: rtl/rs_pkg.sv
// Shared Reed-Solomon constants: GF(2^8) field polynomial, root table limit, root generator FSM encoding.
package rs_pkg;

    localparam logic [8:0] GF_POLY   = 9'h11D;
    localparam logic [7:0] MAX_ROOTS = 8'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } root_state_e;

    function automatic logic [7:0] clamp_roots(input logic [7:0] n);
        return (n > MAX_ROOTS) ? MAX_ROOTS : n;
    endfunction

endpackage

// File: rtl/syndrome_root_gen_if.sv
// Root table transfer bus between the root generator (slave) and the syndrome stage (master).
interface syndrome_root_gen_if;
    logic       send_roots;
    logic [7:0] no_of_parity;
    logic [7:0] root;
    logic [7:0] address;
    logic       roots_ready;
    logic       send_roots_done;

    modport master (
        output send_roots, no_of_parity,
        input  root, address, roots_ready, send_roots_done
    );

    modport slave (
        input  send_roots, no_of_parity,
        output root, address, roots_ready, send_roots_done
    );
endinterface

// File: rtl/gf_mul_alpha.sv
// Combinational multiply by alpha in GF(2^8) over the field polynomial in rs_pkg.
module gf_mul_alpha
    import rs_pkg::*;
(
    input  logic [7:0] i_value,
    output logic [7:0] o_value
);
    assign o_value = {i_value[6:0], 1'b0} ^ (i_value[7] ? GF_POLY[7:0] : 8'h00);
endmodule

// File: rtl/syndrome_root_gen.sv
// Streams the generator roots alpha^i (i = 1..N) to the syndrome stage, one per cycle.
// Build option ROOT_FCR_ZERO_EN: first consecutive root is alpha^0 instead of alpha^1.
module syndrome_root_gen
    import rs_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    syndrome_root_gen_if.slave  bus
);
`ifdef ROOT_FCR_ZERO_EN
    localparam logic [7:0] FIRST_ROOT = 8'h01;
`else
    localparam logic [7:0] FIRST_ROOT = 8'h02;
`endif

    root_state_e r_state, w_state_next;
    logic [7:0]  r_root, w_root_next;
    logic [7:0]  r_address, w_address_next;
    logic [7:0]  r_n_eff, w_n_eff_next;
    logic        r_ready, w_ready_next;
    logic        r_done, w_done_next;
    logic [7:0]  w_root_alpha;
    logic [7:0]  w_n_clamped;

    gf_mul_alpha u_mul (
        .i_value (r_root),
        .o_value (w_root_alpha)
    );

    assign w_n_clamped = clamp_roots(bus.no_of_parity);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_root    <= 8'h00;
            r_address <= 8'h00;
            r_n_eff   <= 8'h00;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_root    <= w_root_next;
            r_address <= w_address_next;
            r_n_eff   <= w_n_eff_next;
            r_ready   <= w_ready_next;
            r_done    <= w_done_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_root_next    = r_root;
        w_address_next = r_address;
        w_n_eff_next   = r_n_eff;
        w_ready_next   = 1'b0;
        w_done_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.send_roots) begin
                    w_n_eff_next = w_n_clamped;
                    if (w_n_clamped == 8'd0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_root_next    = FIRST_ROOT;
                        w_address_next = 8'd1;
                        w_ready_next   = 1'b1;
                        w_state_next   = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                // The pair for address N_eff is on the bus now; stop without advancing.
                if (r_address == r_n_eff) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_root_next    = w_root_alpha;
                    w_address_next = r_address + 8'd1;
                    w_ready_next   = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.send_roots) begin
                    w_done_next = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.root            = r_root;
    assign bus.address         = r_address;
    assign bus.roots_ready     = r_ready;
    assign bus.send_roots_done = r_done;

endmodule

// File: tb/tb_syndrome_root_gen.sv
// Directed bench for syndrome_root_gen: table of whole transfers plus reset and done-hold sequences.
module tb_syndrome_root_gen;
    logic clock;
    logic reset;
    syndrome_root_gen_if bus ();

    syndrome_root_gen dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

`ifdef ROOT_FCR_ZERO_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // alpha^0 .. alpha^32 over x^8+x^4+x^3+x^2+1
    logic [7:0] alpha_pow [0:32] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26,
        8'h4C, 8'h98, 8'h2D, 8'h5A, 8'hB4, 8'h75, 8'hEA, 8'hC9,
        8'h8F, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0,
        8'h9D
    };

    typedef struct {
        logic [7:0] n;
        int         exp_cnt;
        int         probe_addr;
        logic [7:0] probe_root;
    } vec_t;

    vec_t vecs [9];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int exp_root_at(input int addr);
        int idx;
        idx = addr - OFF;
        if (idx < 0 || idx > 32) return -1;
        return int'(alpha_pow[idx]);
    endfunction

    task automatic run_vec(input vec_t v);
        int  cnt;
        int  cyc;
        bit  seen_done;
        bit  probe_seen;
        cnt = 0; cyc = 0; seen_done = 0; probe_seen = 0;
        @(negedge clock);
        bus.no_of_parity = v.n;
        bus.send_roots   = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clock);
            cyc = c;
            if (c == 2) bus.no_of_parity = 8'd1;
            if (bus.roots_ready) begin
                cnt++;
                check("strobe_cycle", c, cnt);
                check("addr_seq", int'(bus.address), cnt);
                check("root_val", int'(bus.root), exp_root_at(int'(bus.address)));
                if (v.probe_addr != 0 && int'(bus.address) == v.probe_addr) begin
                    probe_seen = 1;
                    check("probe_root", int'(bus.root), int'(v.probe_root));
                end
            end
            if (bus.send_roots_done) begin
                seen_done = 1;
                break;
            end
        end
        check("done_seen", int'(seen_done), 1);
        check("done_cycle", cyc, v.exp_cnt + 2);
        check("strobe_count", cnt, v.exp_cnt);
        check("ready_low_done", int'(bus.roots_ready), 0);
        if (v.probe_addr != 0) check("probe_seen", int'(probe_seen), 1);
        if (v.exp_cnt > 0) begin
            check("hold_addr", int'(bus.address), v.exp_cnt);
            check("hold_root", int'(bus.root), exp_root_at(v.exp_cnt));
        end
        bus.send_roots = 1'b0;
        @(negedge clock);
        check("done_clear", int'(bus.send_roots_done), 0);
    endtask

    initial begin
        int cnt;
        bit got;

`ifdef ROOT_FCR_ZERO_EN
        vecs[0] = '{8'd4,  4,  4,  8'h08};
        vecs[1] = '{8'd32, 32, 8,  8'h80};
        vecs[2] = '{8'd32, 32, 16, 8'h26};
        vecs[3] = '{8'd32, 32, 25, 8'h8F};
        vecs[4] = '{8'd32, 32, 32, 8'hC0};
        vecs[5] = '{8'd40, 32, 32, 8'hC0};
        vecs[7] = '{8'd1,  1,  1,  8'h01};
        vecs[8] = '{8'd3,  3,  3,  8'h04};
`else
        vecs[0] = '{8'd4,  4,  4,  8'h10};
        vecs[1] = '{8'd32, 32, 8,  8'h1D};
        vecs[2] = '{8'd32, 32, 16, 8'h4C};
        vecs[3] = '{8'd32, 32, 25, 8'h03};
        vecs[4] = '{8'd32, 32, 32, 8'h9D};
        vecs[5] = '{8'd40, 32, 32, 8'h9D};
        vecs[7] = '{8'd1,  1,  1,  8'h02};
        vecs[8] = '{8'd3,  3,  3,  8'h08};
`endif
        vecs[6] = '{8'd0,  0,  0,  8'h00};

        reset = 1'b1;
        bus.send_roots   = 1'b0;
        bus.no_of_parity = 8'd0;
        #12;
        check("rst_root",  int'(bus.root), 0);
        check("rst_addr",  int'(bus.address), 0);
        check("rst_ready", int'(bus.roots_ready), 0);
        check("rst_done",  int'(bus.send_roots_done), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // done holds while the request stays high, clears one cycle after it drops
        @(negedge clock);
        bus.no_of_parity = 8'd3;
        bus.send_roots   = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.send_roots_done) begin got = 1; break; end
        end
        check("hold_done_seen", int'(got), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("hold_done_high", int'(bus.send_roots_done), 1);
            check("hold_ready_low", int'(bus.roots_ready), 0);
            check("hold_addr_3", int'(bus.address), 3);
        end
        bus.send_roots = 1'b0;
        @(negedge clock);
        check("hold_done_clear", int'(bus.send_roots_done), 0);
        @(negedge clock);

        // asynchronous reset in the middle of an N=16 transfer, then restart
        bus.no_of_parity = 8'd16;
        bus.send_roots   = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 3; c++) begin
            @(negedge clock);
            if (bus.roots_ready) cnt++;
        end
        check("mid_strobes", cnt, 3);
        #1 reset = 1'b1;
        #1;
        check("async_root",  int'(bus.root), 0);
        check("async_addr",  int'(bus.address), 0);
        check("async_ready", int'(bus.roots_ready), 0);
        check("async_done",  int'(bus.send_roots_done), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("restart_ready", int'(bus.roots_ready), 1);
        check("restart_addr",  int'(bus.address), 1);
        check("restart_root",  int'(bus.root), exp_root_at(1));
        cnt = 1;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus.roots_ready) cnt++;
            if (bus.send_roots_done) begin got = 1; break; end
        end
        check("restart_done", int'(got), 1);
        check("restart_count", cnt, 16);
        check("restart_last_addr", int'(bus.address), 16);
        bus.send_roots = 1'b0;
        @(negedge clock);
        check("restart_done_clear", int'(bus.send_roots_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/syndrome_root_gen.md
SYNDROME_ROOT_GEN -- requirements
Module: syndrome_root_gen

Interface
REQ-001 SHALL have port clock, input, 1 bit; sole clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1 bit; one clock, reset asynchronous and active-high.
REQ-003 SHALL have port send_roots, input, 1 bit; level request from syndrome stage for the root table.
REQ-004 SHALL have port no_of_parity, input, 8 bits; number of roots N (2t), sampled at request start.
REQ-005 SHALL have port root, output, 8 bits; GF(2^8) root value, valid while roots_ready=1.
REQ-006 SHALL have port address, output, 8 bits; root index 1..N, valid while roots_ready=1.
REQ-007 SHALL have port roots_ready, output, 1 bit; write strobe, one root/address pair per high cycle.
REQ-008 SHALL have port send_roots_done, output, 1 bit; table transfer complete.

Function
REQ-009 SHALL implement FSM states IDLE, EMIT, DONE.
REQ-010 SHALL, in IDLE with send_roots=1, latch N_eff = min(no_of_parity, 32), load root register with first root, set address=1, go to EMIT (or straight to DONE if N_eff=0).
REQ-011 SHALL, in EMIT, assert roots_ready every cycle, presenting a new root/address each cycle with no gaps; the first pair appears the cycle after the request is sampled.
REQ-012 SHALL advance root each EMIT cycle as root*alpha in GF(2^8), primitive polynomial 0x11D: shift left 1, XOR 0x1D if bit 7 was set.
REQ-013 SHALL increment address by 1 each EMIT cycle; after the pair with address=N_eff, go to DONE with roots_ready=0.
REQ-014 SHALL, in DONE, hold send_roots_done=1 until send_roots=0, then return to IDLE with send_roots_done=0 the following cycle.
REQ-015 SHALL ignore changes on send_roots and no_of_parity during EMIT; transfer always runs to N_eff.
REQ-016 SHALL hold root and address at last-emitted values when roots_ready=0.
REQ-017 SHALL never exceed address 32 or emit address 0.

Reset
REQ-018 SHALL, on reset=1, immediately force state IDLE, root=8'h00, address=8'h00, roots_ready=0, send_roots_done=0, N_eff=0, including mid-EMIT.
REQ-019 SHALL, after reset release with send_roots already high, start a fresh transfer from address 1 on the next clock edge.

Configuration
REQ-020 SHALL support macro ROOT_FCR_ZERO_EN: when defined, address i carries alpha^(i-1) (first root 8'h01); when undefined, address i carries alpha^i (first root 8'h02).
REQ-021 SHALL keep timing, handshake and address sequence identical in both configurations.

Structure
REQ-022 SHALL place GF primitive polynomial constant (0x11D), MAX_ROOTS=32 and the FSM state encoding in shared package rs_pkg.
REQ-023 SHALL implement the multiply-by-alpha step as combinational sub-module gf_mul_alpha (8-bit in, 8-bit out), reusable by the syndrome stage.

Verification
REQ-024 SHALL check: N=4, FCR undefined -> roots 02,04,08,10 at addresses 1..4 on 4 consecutive cycles, then send_roots_done=1.
REQ-025 SHALL check: N=32 -> address 8 root 1D, address 16 root 4C, address 25 root 03, address 32 root 9D; exactly 32 strobes.
REQ-026 SHALL check: N=40 -> clamped, exactly 32 strobes, last address 32; N=0 -> no strobe, send_roots_done=1 two cycles after request.
REQ-027 SHALL check: reset pulsed after 3rd strobe of N=16 -> outputs zero asynchronously; restart emits from address 1, root 02.
REQ-028 SHALL check: ROOT_FCR_ZERO_EN defined, N=3 -> roots 01,02,04; send_roots held high 5 cycles after done -> done stays high, clears one cycle after send_roots falls.
